// File: rtl/ascon_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : ascon_sequencer                                               |
// | Purpose  : Steers one upstream 32-bit word stream into the key, nonce,   |
// |            associated-data and data channels of an Ascon core, then      |
// |            waits for the core tag (with a timeout) and reports done or   |
// |            error.                                                        |
// | Ports    : clk, rst          - clock, synchronous active-high reset      |
// |            start_i, cfg_*_i  - operation request and its configuration   |
// |            abort_i           - cancel the running operation              |
// |            in_word_i/in_valid_i/in_ready_o - upstream stream handshake   |
// |            core_word_o, *_valid_o, *_ready_i - core input channels       |
// |            data_in_type_o, data_in_last_o    - data channel sideband     |
// |            tag_i/tag_valid_i, tag_out_o      - core tag result           |
// |            busy_o, done_o, error_o, mode_o   - status / core mode        |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module ascon_sequencer #(
  parameter int TIMEOUT = 1024
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        start_i,
  input  logic        cfg_mode_i,
  input  logic [1:0]  cfg_type_i,
  input  logic [7:0]  cfg_assoc_len_i,
  input  logic [7:0]  cfg_data_len_i,
  input  logic        abort_i,
  input  logic [31:0] in_word_i,
  input  logic        in_valid_i,
  output logic        in_ready_o,
  output logic        busy_o,
  output logic        done_o,
  output logic        error_o,
  output logic [31:0] tag_out_o,
  output logic        mode_o,
  output logic [31:0] core_word_o,
  output logic        key_valid_o,
  output logic        nonce_valid_o,
  output logic        assoc_valid_o,
  output logic        data_in_valid_o,
  input  logic        key_ready_i,
  input  logic        nonce_ready_i,
  input  logic        assoc_ready_i,
  input  logic        data_in_ready_i,
  output logic [1:0]  data_in_type_o,
  output logic        data_in_last_o,
  input  logic [31:0] tag_i,
  input  logic        tag_valid_i
);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_KEY   = 3'd1;
  localparam logic [2:0] S_NONCE = 3'd2;
  localparam logic [2:0] S_ASSOC = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_TAG   = 3'd5;
  localparam logic [2:0] S_DONE  = 3'd6;

  localparam int            TW       = $clog2(TIMEOUT + 1);
  localparam logic [TW-1:0] TAG_LAST = TW'(TIMEOUT - 1);

  logic [2:0]    state_q, state_d;
  logic [7:0]    wcnt_q, wcnt_d;
  logic [TW-1:0] tcnt_q, tcnt_d;
  logic          mode_q;
  logic [1:0]    type_q;
  logic [7:0]    alen_q;
  logic [7:0]    dlen_q;
  logic          error_q;
  logic [31:0]   tag_q;

  logic w_xfer;
  logic w_start_acc;
  logic w_err_set;
  logic w_data_empty;

  assign w_start_acc  = (state_q == S_IDLE) && start_i;
  assign w_data_empty = (dlen_q == 8'd0);
  // in_ready_o depends only on state and core readies, so this is not a loop
  assign w_xfer       = in_valid_i && in_ready_o;
  assign w_err_set    = ((state_q != S_IDLE) && abort_i) ||
                        ((state_q == S_TAG) && !tag_valid_i && (tcnt_q == TAG_LAST));

  // ---------------------------------------------------------------- registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      tcnt_q  <= '0;
      mode_q  <= 1'b0;
      type_q  <= 2'b00;
      alen_q  <= '0;
      dlen_q  <= '0;
      error_q <= 1'b0;
      tag_q   <= '0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      tcnt_q  <= tcnt_d;
      if (w_start_acc) begin
        mode_q  <= cfg_mode_i;
        type_q  <= cfg_type_i;
        alen_q  <= cfg_assoc_len_i;
        dlen_q  <= cfg_data_len_i;
        error_q <= 1'b0;
      end else if (w_err_set) begin
        error_q <= 1'b1;
      end
      // abort wins over a tag arriving in the same cycle
      if ((state_q == S_TAG) && tag_valid_i && !abort_i) begin
        tag_q <= tag_i;
      end
    end
  end

  // --------------------------------------------------------------- next state
  always_comb begin
    state_d = state_q;
    wcnt_d  = wcnt_q;
    tcnt_d  = tcnt_q;
    if ((state_q != S_IDLE) && abort_i) begin
      state_d = S_IDLE;
    end else begin
      if (w_xfer) begin
        wcnt_d = wcnt_q + 8'd1;
      end
      case (state_q)
        S_IDLE: begin
          if (start_i) state_d = S_KEY;
        end
        S_KEY: begin
          if (w_xfer && (wcnt_q == 8'd3)) state_d = S_NONCE;
        end
        S_NONCE: begin
          if (w_xfer && (wcnt_q == 8'd3)) begin
            state_d = (alen_q == 8'd0) ? S_DATA : S_ASSOC;
          end
        end
        S_ASSOC: begin
          if (w_xfer && (wcnt_q == alen_q - 8'd1)) state_d = S_DATA;
        end
        S_DATA: begin
          if (w_data_empty) begin
            if (data_in_ready_i) state_d = S_TAG;
          end else if (w_xfer && (wcnt_q == dlen_q - 8'd1)) begin
            state_d = S_TAG;
          end
        end
        S_TAG: begin
          if (tag_valid_i) begin
            state_d = S_DONE;
          end else if (tcnt_q == TAG_LAST) begin
            state_d = S_IDLE;
          end else begin
            tcnt_d = tcnt_q + 1'b1;
          end
        end
        S_DONE: begin
          state_d = S_IDLE;
        end
        default: begin
          state_d = S_IDLE;
        end
      endcase
    end
    // both counters are per-state and restart on every transition
    if (state_d != state_q) begin
      wcnt_d = '0;
      tcnt_d = '0;
    end
  end

  // ------------------------------------------------------------------ outputs
  always_comb begin
    in_ready_o      = 1'b0;
    key_valid_o     = 1'b0;
    nonce_valid_o   = 1'b0;
    assoc_valid_o   = 1'b0;
    data_in_valid_o = 1'b0;
    core_word_o     = '0;
    data_in_last_o  = 1'b0;
    data_in_type_o  = 2'b00;
    case (state_q)
      S_KEY: begin
        key_valid_o = in_valid_i;
        in_ready_o  = key_ready_i;
        core_word_o = in_word_i;
      end
      S_NONCE: begin
        nonce_valid_o = in_valid_i;
        in_ready_o    = nonce_ready_i;
        core_word_o   = in_word_i;
      end
      S_ASSOC: begin
        assoc_valid_o = in_valid_i;
        in_ready_o    = assoc_ready_i;
        core_word_o   = in_word_i;
      end
      S_DATA: begin
        if (w_data_empty) begin
          // empty message: a single typeless final transfer, nothing consumed upstream
          data_in_valid_o = 1'b1;
          data_in_last_o  = 1'b1;
        end else begin
          data_in_valid_o = in_valid_i;
          in_ready_o      = data_in_ready_i;
          core_word_o     = in_word_i;
          data_in_type_o  = type_q;
          data_in_last_o  = (wcnt_q == dlen_q - 8'd1);
        end
      end
      default: begin
      end
    endcase
  end

  assign busy_o    = (state_q != S_IDLE);
  assign done_o    = (state_q == S_DONE);
  assign error_o   = error_q;
  assign tag_out_o = tag_q;
  assign mode_o    = mode_q;

endmodule
`default_nettype wire

// File: tb/tb_ascon_sequencer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : tb_ascon_sequencer                                            |
// | Purpose  : Self-checking bench for ascon_sequencer. A transfer-list model |
// |            predicts every output each cycle; directed runs pin the model |
// |            with hand-computed counts and values.                         |
// | Revision : 1.0 - initial release                                         |
// +--------------------------------------------------------------------------+
module tb_ascon_sequencer;

  localparam int TO = 16;
  localparam int P_IDLE = 0;
  localparam int P_LOAD = 1;
  localparam int P_TAG  = 2;
  localparam int P_DONE = 3;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst, start_i, cfg_mode_i, abort_i, in_valid_i, in_ready_o;
  logic [1:0]  cfg_type_i;
  logic [7:0]  cfg_assoc_len_i, cfg_data_len_i;
  logic [31:0] in_word_i, tag_out_o, core_word_o, tag_i;
  logic        busy_o, done_o, error_o, mode_o;
  logic        key_valid_o, nonce_valid_o, assoc_valid_o, data_in_valid_o;
  logic        key_ready_i, nonce_ready_i, assoc_ready_i, data_in_ready_i;
  logic [1:0]  data_in_type_o;
  logic        data_in_last_o, tag_valid_i;

  ascon_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .start_i(start_i), .cfg_mode_i(cfg_mode_i),
    .cfg_type_i(cfg_type_i), .cfg_assoc_len_i(cfg_assoc_len_i),
    .cfg_data_len_i(cfg_data_len_i), .abort_i(abort_i), .in_word_i(in_word_i),
    .in_valid_i(in_valid_i), .in_ready_o(in_ready_o), .busy_o(busy_o),
    .done_o(done_o), .error_o(error_o), .tag_out_o(tag_out_o), .mode_o(mode_o),
    .core_word_o(core_word_o), .key_valid_o(key_valid_o),
    .nonce_valid_o(nonce_valid_o), .assoc_valid_o(assoc_valid_o),
    .data_in_valid_o(data_in_valid_o), .key_ready_i(key_ready_i),
    .nonce_ready_i(nonce_ready_i), .assoc_ready_i(assoc_ready_i),
    .data_in_ready_i(data_in_ready_i), .data_in_type_o(data_in_type_o),
    .data_in_last_o(data_in_last_o), .tag_i(tag_i), .tag_valid_i(tag_valid_i)
  );

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at t=%0t", name, act, exp, $time);
    end
  endtask

  // ------------------------------------------------------------------- model
  // An operation is the ordered list of core transfers it must perform,
  // followed by the tag wait and a one-cycle done.
  typedef struct packed {
    logic [1:0] ch;     // 0 key, 1 nonce, 2 assoc, 3 data
    logic       empty;  // zero-length data marker
    logic       last;
  } xfer_t;

  xfer_t       mq[$];
  xfer_t       cf;
  int          mphase = P_IDLE;
  int          tcnt = 0;
  logic        merr = 1'b0;
  logic        mmode = 1'b0;
  logic [1:0]  mtype = 2'b00;
  logic [31:0] mtag = '0;
  bit          armed = 1'b0;
  logic [31:0] got[$];
  logic [31:0] src[$];

  // direct observations of the DUT used by the literal checks
  int          dx[4];
  int          dones, tagonly;
  logic [31:0] lastw;

  logic [3:0]  vv, rv, ev;
  logic        er, el;
  logic [31:0] ew;
  logic [1:0]  et;

  task automatic push_x(input logic [1:0] ch, input logic e, input logic l);
    xfer_t nx;
    nx.ch = ch; nx.empty = e; nx.last = l;
    mq.push_back(nx);
  endtask

  always @(negedge clk) begin
    #1;
    vv = {data_in_valid_o, assoc_valid_o, nonce_valid_o, key_valid_o};
    rv = {data_in_ready_i, assoc_ready_i, nonce_ready_i, key_ready_i};
    if (armed) begin
      ev = '0; er = 1'b0; ew = '0; el = 1'b0; et = 2'b00;
      if (mphase == P_LOAD) begin
        cf = mq[0];
        if (cf.empty) begin
          ev[cf.ch] = 1'b1;
          el = 1'b1;
        end else begin
          ev[cf.ch] = in_valid_i;
          er = rv[cf.ch];
          ew = in_word_i;
          el = cf.last;
          if (cf.ch == 2'd3) et = mtype;
        end
      end
      chk("busy", 32'(busy_o), 32'(mphase != P_IDLE));
      chk("done", 32'(done_o), 32'(mphase == P_DONE));
      chk("error", 32'(error_o), 32'(merr));
      chk("mode", 32'(mode_o), 32'(mmode));
      chk("tag_out", tag_out_o, mtag);
      chk("valids", 32'(vv), 32'(ev));
      chk("in_ready", 32'(in_ready_o), 32'(er));
      chk("core_word", core_word_o, ew);
      chk("data_last", 32'(data_in_last_o), 32'(el));
      chk("data_type", 32'(data_in_type_o), 32'(et));
      for (int c = 0; c < 4; c++) if (vv[c] && rv[c]) dx[c]++;
      if (done_o) dones++;
      if (data_in_valid_o && data_in_ready_i && data_in_last_o) lastw = core_word_o;
      if (busy_o && (vv == 4'b0) && !in_ready_o && !done_o) tagonly++;
    end
    if (rst) begin
      armed = 1'b1;
      mphase = P_IDLE; merr = 1'b0; mmode = 1'b0; mtype = 2'b00; mtag = '0;
      mq.delete();
    end else if (armed) begin
      case (mphase)
        P_IDLE: begin
          if (start_i) begin
            merr = 1'b0; mmode = cfg_mode_i; mtype = cfg_type_i;
            mq.delete();
            for (int i = 0; i < 4; i++) push_x(2'd0, 1'b0, 1'b0);
            for (int i = 0; i < 4; i++) push_x(2'd1, 1'b0, 1'b0);
            for (int i = 0; i < int'(cfg_assoc_len_i); i++) push_x(2'd2, 1'b0, 1'b0);
            if (cfg_data_len_i == 8'd0) push_x(2'd3, 1'b1, 1'b1);
            else for (int i = 0; i < int'(cfg_data_len_i); i++)
              push_x(2'd3, 1'b0, (i == int'(cfg_data_len_i) - 1));
            mphase = P_LOAD;
          end
        end
        P_LOAD: begin
          if (abort_i) begin
            mphase = P_IDLE; merr = 1'b1;
          end else begin
            cf = mq[0];
            if (cf.empty ? rv[cf.ch] : (in_valid_i && rv[cf.ch])) begin
              if (!cf.empty) got.push_back(in_word_i);
              cf = mq.pop_front();
              if (mq.size() == 0) begin mphase = P_TAG; tcnt = 0; end
            end
          end
        end
        P_TAG: begin
          if (abort_i) begin
            mphase = P_IDLE; merr = 1'b1;
          end else if (tag_valid_i) begin
            mtag = tag_i; mphase = P_DONE;
          end else begin
            tcnt++;
            if (tcnt == TO) begin mphase = P_IDLE; merr = 1'b1; end
          end
        end
        default: begin
          if (abort_i) merr = 1'b1;
          mphase = P_IDLE;
        end
      endcase
    end
  end

  // ------------------------------------------------------------------ driver
  int          p_inval = 100, p_rdy = 100, p_tag = 100, p_abort = 0, p_startn = 0;
  bit          key_tog = 1'b0;
  bit          tagfix = 1'b0;
  logic [31:0] tagword = 32'hDEADBEEF;

  function automatic bit roll(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  task automatic drive(input bit st);
    @(negedge clk);
    start_i    = st;
    in_valid_i = roll(p_inval);
    in_word_i  = (got.size() < src.size()) ? src[got.size()] : $urandom;
    if (key_tog) key_ready_i = ~key_ready_i;
    else key_ready_i = roll(p_rdy);
    nonce_ready_i   = roll(p_rdy);
    assoc_ready_i   = roll(p_rdy);
    data_in_ready_i = roll(p_rdy);
    tag_valid_i = roll(p_tag);
    tag_i       = tagfix ? tagword : $urandom;
    abort_i     = roll(p_abort);
  endtask

  task automatic idle_cycle();
    drive(1'b0);
    abort_i = 1'b0;
    rst = 1'b0;
  endtask

  task automatic run_op(input logic m, input logic [1:0] t, input int a, input int d,
                        input int abort_at, input int rst_at, input bit seqw);
    bit fin;
    got.delete(); src.delete();
    for (int i = 0; i < 8 + a + d; i++) src.push_back(seqw ? 32'(i + 1) : $urandom);
    for (int c = 0; c < 4; c++) dx[c] = 0;
    dones = 0; tagonly = 0; lastw = '0;
    drive(1'b1);
    cfg_mode_i = m; cfg_type_i = t;
    cfg_assoc_len_i = 8'(a); cfg_data_len_i = 8'(d);
    abort_i = 1'b0; rst = 1'b0;
    fin = 1'b0;
    for (int k = 1; k < 5000 && !fin; k++) begin
      drive(roll(p_startn));
      if (k == abort_at) abort_i = 1'b1;
      rst = (k == rst_at);
      #2;
      if (mphase == P_IDLE) fin = 1'b1;
    end
    if (!fin) begin
      total++; bad++;
      $display("FAIL op_budget: operation still running after 5000 cycles, required to finish");
      @(negedge clk) rst = 1'b1;
      @(negedge clk) rst = 1'b0;
    end
    for (int i = 0; i < got.size(); i++) chk("word_order", got[i], src[i]);
  endtask

  // ---------------------------------------------------------------- sequence
  initial begin
    rst = 1'b1; start_i = 1'b0; cfg_mode_i = 1'b0; cfg_type_i = 2'b00;
    cfg_assoc_len_i = '0; cfg_data_len_i = '0; abort_i = 1'b0;
    in_word_i = '0; in_valid_i = 1'b0; key_ready_i = 1'b0; nonce_ready_i = 1'b0;
    assoc_ready_i = 1'b0; data_in_ready_i = 1'b0; tag_i = '0; tag_valid_i = 1'b0;
    for (int c = 0; c < 4; c++) dx[c] = 0;
    dones = 0; tagonly = 0; lastw = '0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    idle_cycle(); idle_cycle(); #3;
    chk("rst_busy", 32'(busy_o), 32'd0);
    chk("rst_error", 32'(error_o), 32'd0);
    chk("rst_tag_out", tag_out_o, 32'd0);

    // words 1..13, cores always ready, tag DEADBEEF
    tagfix = 1'b1;
    run_op(1'b1, 2'b10, 2, 3, -1, -1, 1'b1);
    idle_cycle(); #3;
    chk("r37_key_xfers", 32'(dx[0]), 32'd4);
    chk("r37_nonce_xfers", 32'(dx[1]), 32'd4);
    chk("r37_assoc_xfers", 32'(dx[2]), 32'd2);
    chk("r37_data_xfers", 32'(dx[3]), 32'd3);
    chk("r37_last_word", lastw, 32'd13);
    chk("r37_tag_out", tag_out_o, 32'hDEADBEEF);
    chk("r37_done_pulses", 32'(dones), 32'd1);

    // empty associated data and empty message
    run_op(1'b0, 2'b01, 0, 0, -1, -1, 1'b0);
    idle_cycle(); #3;
    chk("r38_key_xfers", 32'(dx[0]), 32'd4);
    chk("r38_assoc_xfers", 32'(dx[2]), 32'd0);
    chk("r38_data_xfers", 32'(dx[3]), 32'd1);
    chk("r38_tag_cycles", 32'(tagonly), 32'd1);
    chk("r38_done_pulses", 32'(dones), 32'd1);

    // key_ready toggling, gapped upstream
    key_tog = 1'b1; p_inval = 50; p_rdy = 70; p_tag = 40; tagfix = 1'b0;
    run_op(1'b1, 2'b11, 3, 5, -1, -1, 1'b0);
    idle_cycle(); #3;
    key_tog = 1'b0;
    chk("r39_key_xfers", 32'(dx[0]), 32'd4);
    chk("r39_words_moved", 32'(got.size()), 32'd16);

    // tag never arrives
    p_inval = 100; p_rdy = 100; p_tag = 0;
    run_op(1'b0, 2'b01, 1, 1, -1, -1, 1'b0);
    idle_cycle(); #3;
    chk("r40_tag_cycles", 32'(tagonly), 32'd16);
    chk("r40_error", 32'(error_o), 32'd1);
    chk("r40_busy", 32'(busy_o), 32'd0);
    chk("r40_done_pulses", 32'(dones), 32'd0);

    // abort on the second assoc word, then reset during data
    p_tag = 100; tagfix = 1'b1; tagword = 32'h0BADF00D;
    run_op(1'b1, 2'b10, 2, 2, 10, -1, 1'b0);
    idle_cycle(); #3;
    chk("r41_abort_error", 32'(error_o), 32'd1);
    chk("r41_abort_busy", 32'(busy_o), 32'd0);
    chk("r41_abort_done", 32'(dones), 32'd0);
    chk("r41_abort_words", 32'(got.size()), 32'd9);
    run_op(1'b1, 2'b10, 1, 4, -1, 11, 1'b0);
    idle_cycle(); #3;
    chk("r41_rst_error", 32'(error_o), 32'd0);
    chk("r41_rst_mode", 32'(mode_o), 32'd0);
    chk("r41_rst_valids", 32'({key_valid_o, nonce_valid_o, assoc_valid_o, data_in_valid_o}), 32'd0);
    chk("r41_rst_done", 32'(dones), 32'd0);
    run_op(1'b0, 2'b01, 2, 2, -1, -1, 1'b0);
    idle_cycle(); #3;
    chk("r41_restart_done", 32'(dones), 32'd1);
    chk("r41_restart_tag", tag_out_o, 32'h0BADF00D);

    // randomized operations with aborts, stray starts and timeouts
    tagfix = 1'b0;
    for (int r = 0; r < 25; r++) begin
      p_inval = int'($urandom_range(30, 100));
      p_rdy = int'($urandom_range(30, 100));
      p_tag = int'($urandom_range(10, 60));
      p_abort = roll(50) ? 2 : 0;
      p_startn = 10;
      key_tog = roll(30);
      run_op(1'($urandom), 2'($urandom), int'($urandom_range(6)), int'($urandom_range(6)),
             -1, -1, 1'b0);
      idle_cycle();
    end

    // longest lengths
    key_tog = 1'b0; p_inval = 100; p_rdy = 100; p_tag = 100; p_abort = 0; p_startn = 0;
    run_op(1'b1, 2'b11, 255, 255, -1, -1, 1'b0);
    idle_cycle(); #3;
    chk("max_len_words", 32'(got.size()), 32'd518);
    chk("max_len_done", 32'(dones), 32'd1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ascon_sequencer.md
ASCON_SEQUENCER -- requirements
Module: ascon_sequencer

Interface
REQ-001 Parameter TIMEOUT, default 1024: max cycles waiting for tag_valid before error.
REQ-002 clk  input  1  single clock; all logic on rising edge.
REQ-003 rst  input  1  synchronous, active-high reset.
REQ-004 start  input  1  begin one operation; sampled only in IDLE.
REQ-005 cfg_mode  input  1  enc/dec mode, latched on accepted start.
REQ-006 cfg_type  input  2  data type, latched on accepted start.
REQ-007 cfg_assoc_len  input  8  associated-data word count (0..255), latched on start.
REQ-008 cfg_data_len  input  8  data word count (0..255), latched on start.
REQ-009 abort  input  1  cancel current operation.
REQ-010 in_word  input  32  upstream word stream: key, nonce, assoc, data in that order.
REQ-011 in_valid / in_ready  input / output  1 each  upstream handshake.
REQ-012 busy  output  1  high in every state except IDLE.
REQ-013 done  output  1  one-cycle pulse on completion.
REQ-014 error  output  1  sticky until next accepted start or rst.
REQ-015 tag_out  output  32  captured core tag word.
REQ-016 mode  output  1  to core mode; equals latched cfg_mode.
REQ-017 core_word  output  32  drives core key_in, nonce_in, assoc_in, data_in.
REQ-018 key_valid, nonce_valid, assoc_valid, data_in_valid  output  1 each  core channel valids.
REQ-019 key_ready, nonce_ready, assoc_ready, data_in_ready  input  1 each  core channel readies.
REQ-020 data_in_type  output  2  latched cfg_type, or 2'b00 (empty) per REQ-029.
REQ-021 data_in_last  output  1  marks final data transfer.
REQ-022 tag / tag_valid  input  32 / 1  core tag result.

Function
REQ-023 States: IDLE, KEY, NONCE, ASSOC, DATA, TAG, DONE.
REQ-024 IDLE: start=1 latches cfg_*, clears error, enters KEY next cycle; start outside IDLE ignored.
REQ-025 Load states: core_word=in_word; active channel valid=in_valid; in_ready=active channel ready; all other valids 0.
REQ-026 Transfer = in_valid && in_ready; 8-bit word counter increments per transfer, clears on state change.
REQ-027 KEY -> NONCE after 4th transfer; NONCE -> ASSOC after 4th; ASSOC skipped (NONCE -> DATA) when cfg_assoc_len=0.
REQ-028 ASSOC -> DATA after cfg_assoc_len transfers; DATA -> TAG after cfg_data_len transfers; data_in_last=1 on the final DATA word only.
REQ-029 cfg_data_len=0: DATA drives data_in_valid=1, data_in_type=2'b00, data_in_last=1, core_word=0, in_ready=0; leaves on data_in_ready.
REQ-030 TAG: in_ready=0, all valids 0; tag_valid=1 captures tag into tag_out, -> DONE.
REQ-031 TAG cycle counter reaching TIMEOUT without tag_valid: error=1, -> IDLE, no done.
REQ-032 DONE: done=1 for exactly one cycle, -> IDLE.
REQ-033 abort=1 in any non-IDLE state: -> IDLE next cycle, error=1, no done; abort in IDLE ignored; abort has priority over a same-cycle transfer (word not counted, though core may have accepted it).
REQ-034 No combinational path from in_valid to any ready output.

Reset
REQ-035 rst=1: state IDLE, counters 0, busy=0, done=0, error=0, in_ready=0, all valids 0, data_in_last=0, data_in_type=0, mode=0, core_word=0, tag_out=0.
REQ-036 rst mid-operation: all valids drop the cycle after rst sampled; no done pulse.

Verification
REQ-037 start, assoc_len=2, data_len=3, words 1..13 streamed, cores always ready -> 4 key, 4 nonce, 2 assoc, 3 data transfers; data_in_last only with word 13; tag 0xDEADBEEF -> tag_out=0xDEADBEEF, done 1 cycle.
REQ-038 assoc_len=0, data_len=0 -> NONCE goes directly to DATA; one empty transfer type 2'b00, last=1, in_ready=0; done after tag.
REQ-039 key_ready toggled 1/0 each cycle, in_valid randomly gapped -> exactly 4 key words transferred in order, no duplicates or drops.
REQ-040 TIMEOUT=16, tag_valid never asserted -> error=1 after 16 TAG cycles, busy=0, done never pulses.
REQ-041 abort during ASSOC word 1, then rst during DATA of second run -> IDLE, error=1 after abort; after rst all outputs at reset values, new start accepted.
